reg_write_back: RTL

- Write-back (WB) stage of the TinyMIPS pipeline.
- Holds the MEM/WB pipeline register and extracts and extends load data returned by the synchronous data RAM.
- Owns the 32-entry general register file: one write port, two read ports.
- Read ports supply the register-file data that the ID-stage read proxy forwards from. Same-cycle WB writes are bypassed on those read ports.

---
 rtl/reg_write_back_if.sv | 42 ++++
 rtl/reg_write_back.sv | 114 +++++++++++
 2 files changed

// File: rtl/reg_write_back_if.sv
// Bundle of MEM/WB inputs, load data, register read ports and commit debug outputs.
// master drives the pipeline side, slave is the write-back stage.
interface reg_write_back_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  stall_wb;
  logic                  mem_reg_write_en;
  logic [ADDR_WIDTH-1:0] mem_reg_write_addr;
  logic [DATA_WIDTH-1:0] mem_result;
  logic                  mem_load_flag;
  logic [2:0]            mem_load_type;
  logic [1:0]            mem_addr_low;
  logic [DATA_WIDTH-1:0] mem_pc;
  logic [DATA_WIDTH-1:0] ram_read_data;
  logic                  read_en_1;
  logic [ADDR_WIDTH-1:0] read_addr_1;
  logic                  read_en_2;
  logic [ADDR_WIDTH-1:0] read_addr_2;
  logic [DATA_WIDTH-1:0] read_data_1;
  logic [DATA_WIDTH-1:0] read_data_2;
  logic [DATA_WIDTH-1:0] debug_pc_addr;
  logic [3:0]            debug_reg_write_en;
  logic [ADDR_WIDTH-1:0] debug_reg_write_addr;
  logic [DATA_WIDTH-1:0] debug_reg_write_data;

  modport master (
    output stall_wb, mem_reg_write_en, mem_reg_write_addr, mem_result,
           mem_load_flag, mem_load_type, mem_addr_low, mem_pc, ram_read_data,
           read_en_1, read_addr_1, read_en_2, read_addr_2,
    input  read_data_1, read_data_2, debug_pc_addr, debug_reg_write_en,
           debug_reg_write_addr, debug_reg_write_data
  );

  modport slave (
    input  stall_wb, mem_reg_write_en, mem_reg_write_addr, mem_result,
           mem_load_flag, mem_load_type, mem_addr_low, mem_pc, ram_read_data,
           read_en_1, read_addr_1, read_en_2, read_addr_2,
    output read_data_1, read_data_2, debug_pc_addr, debug_reg_write_en,
           debug_reg_write_addr, debug_reg_write_data
  );
endinterface

// File: rtl/reg_write_back.sv
// TinyMIPS write-back stage: MEM/WB register, load extraction/extension and
// the general register file with write-through bypass on both read ports.
module reg_write_back #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input logic              clk,
  input logic              rst,
  reg_write_back_if.slave  bus
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  logic                  wb_write_en_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0] wb_result_q;
  logic                  wb_load_flag_q;
  logic [2:0]            wb_load_type_q;
  logic [1:0]            wb_addr_low_q;
  logic [DATA_WIDTH-1:0] wb_pc_q;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_fire;
  logic                  commit;

  always_comb begin
    load_byte = 8'h00;
    case (wb_addr_low_q)
      2'b00:   load_byte = bus.ram_read_data[7:0];
      2'b01:   load_byte = bus.ram_read_data[15:8];
      2'b10:   load_byte = bus.ram_read_data[23:16];
      default: load_byte = bus.ram_read_data[31:24];
    endcase
    load_half = wb_addr_low_q[1] ? bus.ram_read_data[31:16] : bus.ram_read_data[15:0];
  end

  // Undefined load types fall back to a full-word load.
  always_comb begin
    write_data = bus.ram_read_data;
    if (!wb_load_flag_q) begin
      write_data = wb_result_q;
    end else begin
      case (wb_load_type_q)
        LT_LB:   write_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
        LT_LBU:  write_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
        LT_LH:   write_data = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
        LT_LHU:  write_data = {{(DATA_WIDTH-16){1'b0}}, load_half};
        LT_LW:   write_data = bus.ram_read_data;
        default: write_data = bus.ram_read_data;
      endcase
    end
  end

  assign write_fire = wb_write_en_q && !bus.stall_wb;
  assign commit     = write_fire && (wb_addr_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_write_en_q  <= 1'b0;
      wb_addr_q      <= '0;
      wb_result_q    <= '0;
      wb_load_flag_q <= 1'b0;
      wb_load_type_q <= 3'b000;
      wb_addr_low_q  <= 2'b00;
      wb_pc_q        <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (!bus.stall_wb) begin
        wb_write_en_q  <= bus.mem_reg_write_en;
        wb_addr_q      <= bus.mem_reg_write_addr;
        wb_result_q    <= bus.mem_result;
        wb_load_flag_q <= bus.mem_load_flag;
        wb_load_type_q <= bus.mem_load_type;
        wb_addr_low_q  <= bus.mem_addr_low;
        wb_pc_q        <= bus.mem_pc;
      end
      if (commit) begin
        regs_q[wb_addr_q] <= write_data;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic                  en,
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored
  );
    if (!en || addr == '0) return '0;
    // Forward the value being committed this cycle so ID sees it one cycle early.
    if (commit && addr == wb_addr_q) return write_data;
    return stored;
  endfunction

  assign bus.read_data_1 = read_port(bus.read_en_1, bus.read_addr_1, regs_q[bus.read_addr_1]);
  assign bus.read_data_2 = read_port(bus.read_en_2, bus.read_addr_2, regs_q[bus.read_addr_2]);

  // Debug enable reflects the commit attempt, including writes aimed at $0.
  assign bus.debug_pc_addr        = wb_pc_q;
  assign bus.debug_reg_write_en   = {4{write_fire}};
  assign bus.debug_reg_write_addr = wb_addr_q;
  assign bus.debug_reg_write_data = write_data;

endmodule
